mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory-access pipeline stage between the execute stage and the write-back stage of the 5-stage LoongArch core. It takes the execute stage's result bundle, collects the load data returned by the synchronous data SRAM (one cycle after the address was issued in execute), and selects the final result. It forwards the write-back bundle and publishes a bypass bus to decode. It keeps load data correct across write-back back-pressure by capturing it in a one-entry hold buffer.

Parameters:
ES_TO_MS_WD, 71, width of es_to_ms_bus = {rf_or_mem[70], rf_we[69], dest[68:64], pc[63:32], alu_result[31:0]}
MS_TO_WS_WD, 70, width of ms_to_ws_bus = {rf_we[69], dest[68:64], pc[63:32], final_result[31:0]}
MS_FWD_WD, 39, width of ms_fwd_bus = {fwd_we[38], is_load[37], dest[36:32], value[31:0]}

Ports:
clk  input  1  single clock, all state updates on its rising edge
rst  input  1  synchronous, active-high reset
es_to_ms_valid  input  1  execute stage holds a valid instruction
es_to_ms_bus  input  ES_TO_MS_WD  execute result bundle
ms_allow_in  output  1  mem_stage can accept from execute this cycle
ws_allow_in  input  1  write-back can accept this cycle
ms_to_ws_valid  output  1  mem_stage offers a valid instruction
ms_to_ws_bus  output  MS_TO_WS_WD  write-back bundle
data_sram_rdata  input  32  SRAM read data, valid in the first cycle after acceptance
ms_fwd_bus  output  MS_FWD_WD  bypass/hazard information to decode

Behaviour:
- Pipeline register r_es_bus loads es_to_ms_bus when es_to_ms_valid && ms_allow_in. It holds its value otherwise and has no reset.
- ms_valid: cleared to 0 on rst. Otherwise, when ms_allow_in, it takes es_to_ms_valid; it holds when ms_allow_in=0.
- ms_ready_go = 1 (fixed single-cycle stage).
- ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- first_cycle flag: set to 1 on the edge that accepts a new instruction; cleared on every other edge; 0 after rst.
- Hold buffer (rdata_buf, buf_valid):
  - On an edge where first_cycle=1, ms_valid=1 and ws_allow_in=0: capture rdata_buf <= data_sram_rdata and set buf_valid <= 1.
  - buf_valid clears on any edge where ms_allow_in=1, and on rst.
  - rdata_buf has no reset.
- load_data = buf_valid ? rdata_buf : data_sram_rdata. Raw SRAM data is used only while first_cycle=1.
- final_result = rf_or_mem ? load_data : alu_result. Full 32-bit word, no extension.
- ms_to_ws_bus = {rf_we, dest, pc, final_result}. It is combinational from the register and buffer.
- ms_fwd_bus:
  - fwd_we = ms_valid && rf_we && (dest != 0).
  - is_load = ms_valid && rf_or_mem.
  - value = final_result.
  - The value is always usable in this stage; decode needs no stall on a MEM-stage producer.
- Reset values: ms_valid=0, first_cycle=0, buf_valid=0, ms_to_ws_valid=0, ms_allow_in=1, fwd_we=0, is_load=0. Other bus fields are don't-care while valid=0.
- Simultaneous events:
  - Accept and handoff in the same edge: the new instruction overwrites the register, first_cycle=1, buf_valid=0.
  - rst together with es_to_ms_valid: rst wins, ms_valid=0.
- Reset mid-stall: a buffered load is discarded; after rst the stage is empty.
- Stores pass through as non-load, non-writing instructions (rf_we=0). This stage makes no SRAM write.

Decomposition:
- Shared header (DEFINE.vh) holds ES_TO_MS_WD, MS_TO_WS_WD and MS_FWD_WD plus the field bit-position constants, so that execute, mem, write-back and decode slice the buses identically.
- One natural sub-module: mem_rdata_hold (first_cycle, buf_valid, rdata_buf and load_data select). The rest is top-level glue.

Test Plan:
- Non-load, no stall: bus with rf_or_mem=0, rf_we=1, dest=5, pc=0x1c000010, alu=0x1234 -> next cycle ms_to_ws_valid=1, final_result=0x1234, fwd_we=1, is_load=0.
- Load, no stall: rf_or_mem=1, dest=7; data_sram_rdata=0xDEADBEEF in the first MEM cycle -> final_result=0xDEADBEEF and handoff that cycle; buf_valid stays 0.
- Load with 3-cycle ws_allow_in=0: rdata=0xCAFEF00D in the first cycle, then garbage -> final_result stays 0xCAFEF00D for all stall cycles; ms_allow_in=0 during the stall; buf_valid=1 from the 2nd cycle; clears on release.
- Back-to-back: a load then an ALU op with ws_allow_in=1 -> one handoff per cycle; the second result is the ALU value, not stale buffer data.
- dest=0 write (rf_we=1, dest=0) -> fwd_we=0; ms_to_ws_bus still carries rf_we=1.
- rst asserted during a buffered stall -> next cycle ms_valid=0, buf_valid=0, ms_allow_in=1, ms_to_ws_valid=0; the following load uses live SRAM data.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared bus widths, field positions and payload layouts for the execute -> mem -> write-back path.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_WD = 71;
  localparam int unsigned MS_TO_WS_WD = 70;
  localparam int unsigned MS_FWD_WD   = 39;
  localparam int unsigned DATA_WD     = 32;
  localparam int unsigned REG_IDX_WD  = 5;

  // Field positions so every stage slices the flat buses identically
  localparam int unsigned ES_RF_OR_MEM_BIT = 70;
  localparam int unsigned ES_RF_WE_BIT     = 69;
  localparam int unsigned ES_DEST_LSB      = 64;
  localparam int unsigned ES_PC_LSB        = 32;
  localparam int unsigned WS_RF_WE_BIT     = 69;
  localparam int unsigned WS_DEST_LSB      = 64;
  localparam int unsigned WS_PC_LSB        = 32;
  localparam int unsigned FWD_WE_BIT       = 38;
  localparam int unsigned FWD_IS_LOAD_BIT  = 37;
  localparam int unsigned FWD_DEST_LSB     = 32;

  typedef struct packed {
    logic                  rf_or_mem;
    logic                  rf_we;
    logic [REG_IDX_WD-1:0] dest;
    logic [DATA_WD-1:0]    pc;
    logic [DATA_WD-1:0]    alu_result;
  } es_to_ms_t;

  typedef struct packed {
    logic                  rf_we;
    logic [REG_IDX_WD-1:0] dest;
    logic [DATA_WD-1:0]    pc;
    logic [DATA_WD-1:0]    final_result;
  } ms_to_ws_t;

  typedef struct packed {
    logic                  fwd_we;
    logic                  is_load;
    logic [REG_IDX_WD-1:0] dest;
    logic [DATA_WD-1:0]    value;
  } ms_fwd_t;

endpackage

// File: rtl/mem_stage_rdata_hold.sv
// Keeps SRAM load data stable while write-back stalls: the SRAM word is only valid in
// the first MEM cycle, so it is captured into a one-entry buffer if handoff is blocked.
module mem_stage_rdata_hold
  import mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               ms_valid,
  input  logic               ms_allow_in,
  input  logic               ws_allow_in,
  input  logic [DATA_WD-1:0] data_sram_rdata,
  output logic [DATA_WD-1:0] load_data_c
);

  logic               first_cycle_q, first_cycle_d;
  logic               buf_valid_q,   buf_valid_d;
  logic [DATA_WD-1:0] rdata_buf_q,   rdata_buf_d;
  logic               capture;

  always_comb begin
    first_cycle_d = accept;
    capture       = first_cycle_q && ms_valid && !ws_allow_in;
    buf_valid_d   = buf_valid_q;
    rdata_buf_d   = rdata_buf_q;
    if (capture) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
    // Leaving the stage (or an empty stage) always releases the buffer
    if (ms_allow_in) begin
      buf_valid_d = 1'b0;
    end
    load_data_c = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_cycle_q <= 1'b0;
      buf_valid_q   <= 1'b0;
    end else begin
      first_cycle_q <= first_cycle_d;
      buf_valid_q   <= buf_valid_d;
    end
  end

  // Data payload carries no reset; buf_valid_q qualifies it
  always_ff @(posedge clk) begin
    rdata_buf_q <= rdata_buf_d;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bundle, merges SRAM load data,
// and drives the write-back bundle plus the decode bypass bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   ms_allow_in,
  input  logic                   ws_allow_in,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  input  logic [DATA_WD-1:0]     data_sram_rdata,
  output logic [MS_FWD_WD-1:0]   ms_fwd_bus
);

  es_to_ms_t          r_es_bus_q, r_es_bus_d;
  logic               ms_valid_q, ms_valid_d;
  logic               ms_ready_go;
  logic               accept;
  logic [DATA_WD-1:0] load_data;
  logic [DATA_WD-1:0] final_result;
  ms_to_ws_t          ws_bus;
  ms_fwd_t            fwd_bus;

  always_comb begin
    ms_ready_go    = 1'b1;
    ms_allow_in    = !ms_valid_q || (ms_ready_go && ws_allow_in);
    ms_to_ws_valid = ms_valid_q && ms_ready_go;
    accept         = es_to_ms_valid && ms_allow_in;
    ms_valid_d     = ms_allow_in ? es_to_ms_valid : ms_valid_q;
    r_es_bus_d     = accept ? es_to_ms_t'(es_to_ms_bus) : r_es_bus_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_valid_q <= 1'b0;
    end else begin
      ms_valid_q <= ms_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    r_es_bus_q <= r_es_bus_d;
  end

  mem_stage_rdata_hold u_rdata_hold (
    .clk             (clk),
    .rst             (rst),
    .accept          (accept),
    .ms_valid        (ms_valid_q),
    .ms_allow_in     (ms_allow_in),
    .ws_allow_in     (ws_allow_in),
    .data_sram_rdata (data_sram_rdata),
    .load_data_c     (load_data)
  );

  // Result select and outgoing bundles; the value is final here, so no load-use stall
  always_comb begin
    final_result        = r_es_bus_q.rf_or_mem ? load_data : r_es_bus_q.alu_result;
    ws_bus.rf_we        = r_es_bus_q.rf_we;
    ws_bus.dest         = r_es_bus_q.dest;
    ws_bus.pc           = r_es_bus_q.pc;
    ws_bus.final_result = final_result;
    fwd_bus.fwd_we      = ms_valid_q && r_es_bus_q.rf_we && (r_es_bus_q.dest != REG_IDX_WD'(0));
    fwd_bus.is_load     = ms_valid_q && r_es_bus_q.rf_or_mem;
    fwd_bus.dest        = r_es_bus_q.dest;
    fwd_bus.value       = final_result;
    ms_to_ws_bus        = ws_bus;
    ms_fwd_bus          = fwd_bus;
  end

endmodule
